// File: rtl/npu_pkg.sv
// Shared definitions for the NPU compute sequencer and its datapath helpers.
//   state_t        : sequencer FSM encoding (also exported on the debug state port)
//   ACT_NONE/RELU  : activation select codes as seen on CONFIG[9:8]
//   FRAC_BITS      : fractional bits of the Q8.8 element format
//   SAT_MAX/SAT_MIN: Q8.8 saturation bounds
package npu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]  ACT_NONE  = 2'd0;
  localparam logic [1:0]  ACT_RELU  = 2'd1;
  localparam int          FRAC_BITS = 8;
  localparam logic [15:0] SAT_MAX   = 16'h7FFF;
  localparam logic [15:0] SAT_MIN   = 16'h8000;

endpackage

// File: rtl/npu_act_sat.sv
// Combinational output stage: arithmetic shift of the accumulator down to the
// Q8.8 scale, saturation to 16 bits, then the selected activation.
// Ports:
//   acc    in  ACC_WIDTH  signed accumulator
//   act    in  2          activation code (ACT_RELU, anything else = none)
//   result out DATA_WIDTH activated, saturated element
module npu_act_sat
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 36
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic        [1:0]            act,
  output logic        [DATA_WIDTH-1:0] result
);

  logic signed [ACC_WIDTH-1:0]  shifted;
  logic        [DATA_WIDTH-1:0] sat;

  // >>> truncates toward minus infinity, which is the intended rounding.
  assign shifted = acc >>> FRAC_BITS;

  always_comb begin
    sat = shifted[DATA_WIDTH-1:0];
    // The value fits only if every bit above the result sign bit equals the sign.
    if (!shifted[ACC_WIDTH-1] && (|shifted[ACC_WIDTH-2:DATA_WIDTH-1])) begin
      sat = SAT_MAX;
    end else if (shifted[ACC_WIDTH-1] && !(&shifted[ACC_WIDTH-2:DATA_WIDTH-1])) begin
      sat = SAT_MIN;
    end
    result = sat;
    if (act == ACT_RELU && sat[DATA_WIDTH-1]) begin
      result = '0;
    end
  end

endmodule

// File: rtl/npu_compute_sched.sv
// Matrix-vector sequencer: on start computes y = W*x in Q8.8, one row at a
// time, with a single MAC, then writes the saturated/activated row result.
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   start, soft_rst      CTRL pulse / level (soft_rst is a synchronous clear)
//   cfg_size, cfg_act    CONFIG: N (1..MATRIX_SIZE) and activation code
//   busy, done, err_cfg  STATUS bits (done and err_cfg sticky)
//   irq                  1-cycle completion pulse
//   w_rd_*               weight buffer read port, data 1 cycle after enable
//   x_rd_*               input buffer read port, data 1 cycle after enable
//   y_wr_*               output buffer write port
//   dbg_state            current FSM state
// Buffer read ports: enable and address are valid during a RUN cycle and the
// buffer returns data on the following cycle; there is no backpressure.
module npu_compute_sched
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MATRIX_SIZE = 8,
  parameter int ACC_WIDTH   = 36
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  soft_rst,
  input  logic [3:0]            cfg_size,
  input  logic [1:0]            cfg_act,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg,
  output logic                  irq,
  output logic                  w_rd_en,
  output logic [5:0]            w_rd_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  output logic                  x_rd_en,
  output logic [2:0]            x_rd_addr,
  input  logic [DATA_WIDTH-1:0] x_rd_data,
  output logic                  y_wr_en,
  output logic [2:0]            y_wr_addr,
  output logic [DATA_WIDTH-1:0] y_wr_data,
  output logic [2:0]            dbg_state
);

  localparam logic [3:0] MAX_N = 4'(MATRIX_SIZE);

  state_t                          state, state_n;
  logic        [3:0]               size_q;
  logic        [1:0]               act_q;
  logic        [2:0]               row, col;
  logic signed [ACC_WIDTH-1:0]     acc;
  logic signed [2*DATA_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]     prod_ext;
  logic                            size_ok, last_col, last_row;

  assign size_ok  = (cfg_size != 4'd0) && (cfg_size <= MAX_N);
  assign last_col = (4'(col) == size_q - 4'd1);
  assign last_row = (4'(row) + 4'd1 == size_q);

  assign prod     = $signed(w_rd_data) * $signed(x_rd_data);
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = size_ok ? S_RUN : S_DONE;
      S_RUN:   if (last_col) state_n = S_DRAIN;
      S_DRAIN: state_n = S_WRITE;
      S_WRITE: state_n = last_row ? S_DONE : S_RUN;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || soft_rst) begin
      state   <= S_IDLE;
      size_q  <= '0;
      act_q   <= '0;
      row     <= '0;
      col     <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cfg <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state <= state_n;
      irq   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            size_q  <= cfg_size;
            act_q   <= cfg_act;
            done    <= 1'b0;
            row     <= '0;
            col     <= '0;
            busy    <= size_ok;
            err_cfg <= !size_ok;
          end
        end
        S_RUN: begin
          // Data arriving in the first cycle of a row belongs to no product.
          acc <= (col == 3'd0) ? '0 : acc + prod_ext;
          col <= last_col ? 3'd0 : col + 3'd1;
        end
        S_DRAIN: acc <= acc + prod_ext;
        S_WRITE: begin
          if (last_row) begin
            row  <= '0;
            busy <= 1'b0;
          end else begin
            row <= row + 3'd1;
          end
        end
        S_DONE: begin
          irq  <= 1'b1;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Row-major weight address i*MATRIX_SIZE+j; MATRIX_SIZE is a power of two.
  assign w_rd_en   = (state == S_RUN);
  assign x_rd_en   = (state == S_RUN);
  assign w_rd_addr = {row, col};
  assign x_rd_addr = col;
  assign y_wr_en   = (state == S_WRITE);
  assign y_wr_addr = row;
  assign dbg_state = state;

  npu_act_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_act_sat (
    .acc    (acc),
    .act    (act_q),
    .result (y_wr_data)
  );

endmodule

// File: tb/tb_npu_compute_sched.sv
module tb_npu_compute_sched;

  // ---------------- clock / reset ----------------
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        soft_rst = 1'b0;
  logic [3:0]  cfg_size = 4'd0;
  logic [1:0]  cfg_act = 2'd0;
  logic        busy, done, err_cfg, irq;
  logic        w_rd_en, x_rd_en, y_wr_en;
  logic [5:0]  w_rd_addr;
  logic [2:0]  x_rd_addr, y_wr_addr, dbg_state;
  logic [15:0] w_rd_data = 16'h0;
  logic [15:0] x_rd_data = 16'h0;
  logic [15:0] y_wr_data;

  always #5 aclk = ~aclk;

  npu_compute_sched dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .soft_rst  (soft_rst),
    .cfg_size  (cfg_size),
    .cfg_act   (cfg_act),
    .busy      (busy),
    .done      (done),
    .err_cfg   (err_cfg),
    .irq       (irq),
    .w_rd_en   (w_rd_en),
    .w_rd_addr (w_rd_addr),
    .w_rd_data (w_rd_data),
    .x_rd_en   (x_rd_en),
    .x_rd_addr (x_rd_addr),
    .x_rd_data (x_rd_data),
    .y_wr_en   (y_wr_en),
    .y_wr_addr (y_wr_addr),
    .y_wr_data (y_wr_data),
    .dbg_state (dbg_state)
  );

  // ---------------- buffer models and activity scoreboard ----------------
  logic [15:0] w_mem [64];
  logic [15:0] x_mem [8];
  logic [15:0] y_mem [8];
  logic        clr_stats = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, irq_cnt = 0, order_bad = 0;
  int          max_waddr = 0, exp_yaddr = 0;
  int          checks = 0, errors = 0;

  always @(posedge aclk) begin
    w_rd_data <= w_rd_en ? w_mem[w_rd_addr] : 16'h0;
    x_rd_data <= x_rd_en ? x_mem[x_rd_addr] : 16'h0;
    if (clr_stats) begin
      rd_cnt    <= 0;
      wr_cnt    <= 0;
      irq_cnt   <= 0;
      order_bad <= 0;
      max_waddr <= 0;
      exp_yaddr <= 0;
      for (int i = 0; i < 8; i++) y_mem[i] <= 16'hDEAD;
    end else begin
      if (w_rd_en || x_rd_en) rd_cnt <= rd_cnt + 1;
      if (w_rd_en && int'(w_rd_addr) > max_waddr) max_waddr <= int'(w_rd_addr);
      if (y_wr_en) begin
        y_mem[y_wr_addr] <= y_wr_data;
        wr_cnt <= wr_cnt + 1;
        if (int'(y_wr_addr) != exp_yaddr) order_bad <= order_bad + 1;
        exp_yaddr <= exp_yaddr + 1;
      end
      if (irq) irq_cnt <= irq_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    @(negedge aclk);
    clr_stats = 1'b1;
    @(negedge aclk);
    clr_stats = 1'b0;
  endtask

  task automatic set_w(input logic [15:0] diag, input logic [15:0] off);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        w_mem[i*8+j] = (i == j) ? diag : off;
  endtask

  task automatic set_x(input logic [15:0] v);
    for (int i = 0; i < 8; i++) x_mem[i] = v;
  endtask

  // Leaves the caller #1 after the edge that samples start (edge 0).
  task automatic pulse_start(input logic [3:0] n, input logic [1:0] act);
    @(negedge aclk);
    cfg_size = n;
    cfg_act  = act;
    start    = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  // Full run with uniform expected row value; meddle changes cfg after start
  // and fires an extra start mid-run, neither of which may have any effect.
  task automatic run(input string tag, input logic [3:0] n, input logic [1:0] act,
                     input logic [15:0] exp_y, input bit meddle);
    int cyc, bc, nn;
    nn = int'(n);
    clear_stats();
    pulse_start(n, act);
    cyc = 0;
    bc  = busy ? 1 : 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge aclk);
      #1;
      cyc++;
      if (meddle && cyc == 1) begin
        cfg_size = 4'd8;
        cfg_act  = 2'd1;
      end
      if (meddle && cyc == 10) begin
        cfg_size = 4'd2;
        start    = 1'b1;
      end
      if (meddle && cyc == 11) start = 1'b0;
      if (done) break;
      if (busy) bc++;
    end
    check({tag, "_latency"}, cyc, nn*(nn+2)+1);
    check({tag, "_busy_cycles"}, bc, nn*(nn+2));
    check({tag, "_err_cfg"}, err_cfg, 0);
    repeat (2) @(posedge aclk);
    #1;
    check({tag, "_irq_pulses"}, irq_cnt, 1);
    check({tag, "_irq_low"}, irq, 0);
    check({tag, "_done_held"}, done, 1);
    check({tag, "_writes"}, wr_cnt, nn);
    check({tag, "_order_bad"}, order_bad, 0);
    check({tag, "_reads"}, rd_cnt, nn*nn);
    check({tag, "_max_waddr"}, max_waddr, (nn-1)*8 + nn-1);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_y%0d", tag, i), y_mem[i], (i < nn) ? exp_y : 16'hDEAD);
  endtask

  task automatic run_err(input string tag, input logic [3:0] n);
    int cyc;
    clear_stats();
    pulse_start(n, 2'd0);
    check({tag, "_err_set"}, err_cfg, 1);
    check({tag, "_busy"}, busy, 0);
    cyc = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge aclk);
      #1;
      cyc++;
      if (done) break;
    end
    check({tag, "_latency"}, cyc, 1);
    repeat (3) @(posedge aclk);
    #1;
    check({tag, "_irq_pulses"}, irq_cnt, 1);
    check({tag, "_reads"}, rd_cnt, 0);
    check({tag, "_writes"}, wr_cnt, 0);
    check({tag, "_err_held"}, err_cfg, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_w(16'h0, 16'h0);
    set_x(16'h0);
    for (int i = 0; i < 8; i++) y_mem[i] = 16'hDEAD;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_cfg, 0);
    check("rst_irq", irq, 0);
    check("rst_wen", y_wr_en, 0);
    check("rst_ren", w_rd_en, 0);
    check("rst_state", dbg_state, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Identity, x = 1.0
    set_w(16'h0100, 16'h0);
    set_x(16'h0100);
    run("ident", 4'd8, 2'd0, 16'h0100, 1'b0);

    // diag(2.0): ReLU positive, ReLU negative, no activation negative
    set_w(16'h0200, 16'h0);
    run("diag_relu", 4'd8, 2'd1, 16'h0200, 1'b0);
    set_x(16'hFF00);
    run("diag_relu_neg", 4'd8, 2'd1, 16'h0000, 1'b0);
    run("diag_none_neg", 4'd8, 2'd0, 16'hFE00, 1'b0);

    // Saturation both directions
    set_w(16'h7F00, 16'h7F00);
    set_x(16'h7F00);
    run("sat_pos", 4'd8, 2'd0, 16'h7FFF, 1'b0);
    set_w(16'h8100, 16'h8100);
    run("sat_neg", 4'd8, 2'd0, 16'h8000, 1'b0);

    // N=4 with cfg changes and an ignored start mid-run
    set_w(16'h0100, 16'h0);
    set_x(16'hFF00);
    run("size4", 4'd4, 2'd0, 16'hFF00, 1'b1);

    // Bad sizes, then a good run must clear err_cfg
    run_err("size0", 4'd0);
    run_err("size9", 4'd9);
    set_x(16'h0100);
    run("after_err", 4'd2, 2'd0, 16'h0100, 1'b0);

    // soft_rst at cycle 30 of an 8x8 run: three rows already written
    clear_stats();
    pulse_start(4'd8, 2'd0);
    repeat (30) @(posedge aclk);
    #1;
    check("srst_pre_writes", wr_cnt, 3);
    soft_rst = 1'b1;
    @(posedge aclk);
    #1;
    check("srst_busy", busy, 0);
    check("srst_state", dbg_state, 0);
    check("srst_done", done, 0);
    start = 1'b1;
    @(posedge aclk);
    #1;
    check("srst_beats_start", busy, 0);
    start    = 1'b0;
    soft_rst = 1'b0;
    repeat (100) @(posedge aclk);
    #1;
    check("srst_post_writes", wr_cnt, 3);
    check("srst_irq", irq_cnt, 0);
    check("srst_idle", busy, 0);
    run("after_srst", 4'd8, 2'd0, 16'h0100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
